time_ctrl: RTL

TIME_CTRL -- requirements
Module: time_ctrl

---
 rtl/time_ctrl_if.sv | 27 ++
 rtl/time_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/time_ctrl_if.sv
// time_ctrl_if -- button inputs and BCD display outputs of the time_ctrl clock.
//   btn_mode, btn_inc : debounced clk-synchronous button levels
//   hour1/hour0       : BCD hour tens (0..2) / units (0..9)
//   min1/min0         : BCD minute tens (0..5) / units (0..9)
//   blank             : per-digit off request {hour1, hour0, min1, min0}
//   mode              : 00 RUN, 01 SET_HOUR, 10 SET_MIN
// master drives the buttons and observes the display; slave is the clock core.
interface time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] hour1;
    logic [3:0] hour0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [3:0] blank;
    logic [1:0] mode;

    modport master (
        output btn_mode, btn_inc,
        input  hour1, hour0, min1, min0, blank, mode
    );

    modport slave (
        input  btn_mode, btn_inc,
        output hour1, hour0, min1, min0, blank, mode
    );
endinterface

// File: rtl/time_ctrl.sv
// time_ctrl -- 24-hour BCD clock with RUN / SET_HOUR / SET_MIN modes.
//   clk   : single clock, all state on its rising edge
//   rst_n : asynchronous active-low reset (time 00:00, RUN, blank 0000)
//   tc    : time_ctrl_if.slave -- buttons in, BCD digits / blank / mode out
// Parameters:
//   TICK_DIV  : clk cycles per minute tick (>= 2)
//   BLINK_DIV : clk cycles per blink half-period (>= 2)
// Optional feature: define TIME_CTRL_BLINK_EN to blink the field being set;
// without it blank is constant 0000 and no blink counter exists.
module time_ctrl #(
    parameter longint unsigned TICK_DIV  = 64'd6000000000,
    parameter int unsigned     BLINK_DIV = 25000000
) (
    input  logic      clk,
    input  logic      rst_n,
    time_ctrl_if.slave tc
);
    localparam int unsigned   PW       = (TICK_DIV > 64'd2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 64'd1);

    if (TICK_DIV < 64'd2 || BLINK_DIV < 2) begin : g_param_check
        $error("time_ctrl: TICK_DIV and BLINK_DIV must both be >= 2");
    end

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    h1_q, h1_d;
    logic [3:0]    h0_q, h0_d;
    logic [2:0]    m1_q, m1_d;
    logic [3:0]    m0_q, m0_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          btn_mode_q, btn_inc_q;
    logic          mode_edge, inc_edge, tick;
    logic [7:0]    min_next;
    logic [5:0]    hour_next;

    // {carry_to_hour, min1, min0}
    function automatic logic [7:0] min_inc(input logic [2:0] m1, input logic [3:0] m0);
        if (m0 != 4'd9)
            return {1'b0, m1, m0 + 4'd1};
        else if (m1 != 3'd5)
            return {1'b0, m1 + 3'd1, 4'd0};
        else
            return {1'b1, 3'd0, 4'd0};
    endfunction

    // {hour1, hour0}, 23 wraps to 00
    function automatic logic [5:0] hour_inc(input logic [1:0] h1, input logic [3:0] h0);
        if (h1 == 2'd2 && h0 == 4'd3)
            return '0;
        else if (h0 == 4'd9)
            return {h1 + 2'd1, 4'd0};
        else
            return {h1, h0 + 4'd1};
    endfunction

    always_comb begin
        mode_edge = tc.btn_mode & ~btn_mode_q;
        // a simultaneous mode edge swallows the increment
        inc_edge  = tc.btn_inc & ~btn_inc_q & ~mode_edge;
        tick      = (state_q == RUN) && (pre_q == PRE_LAST);
        min_next  = min_inc(m1_q, m0_q);
        hour_next = hour_inc(h1_q, h0_q);

        state_d = state_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;

        // time update depends only on the current state, so a tick that
        // coincides with a mode edge out of RUN is still applied
        case (state_q)
            RUN: begin
                if (tick) begin
                    {m1_d, m0_d} = min_next[6:0];
                    if (min_next[7])
                        {h1_d, h0_d} = hour_next;
                end
            end
            SET_HOUR: if (inc_edge) {h1_d, h0_d} = hour_next;
            SET_MIN:  if (inc_edge) {m1_d, m0_d} = min_next[6:0];
            default: ;
        endcase

        if (mode_edge) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end

        // held at 0 outside RUN, so re-entering RUN starts a full period
        if (state_q != RUN || state_d != RUN || tick)
            pre_d = '0;
        else
            pre_d = pre_q + PW'(1);
    end

`ifdef TIME_CTRL_BLINK_EN
    localparam int unsigned   BW        = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_q, blank_d;

    always_comb begin
        if (mode_edge) begin
            blk_cnt_d = '0;
            phase_d   = 1'b0;
        end else if (blk_cnt_q == BLNK_LAST) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end else begin
            blk_cnt_d = blk_cnt_q + BW'(1);
            phase_d   = phase_q;
        end

        // derived from next state/phase so blank stays aligned with mode
        case (state_d)
            SET_HOUR: blank_d = {phase_d, phase_d, 2'b00};
            SET_MIN:  blank_d = {2'b00, phase_d, phase_d};
            default:  blank_d = '0;
        endcase
    end

    assign tc.blank = blank_q;
`else
    assign tc.blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            h1_q       <= '0;
            h0_q       <= '0;
            m1_q       <= '0;
            m0_q       <= '0;
            pre_q      <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
`ifdef TIME_CTRL_BLINK_EN
            blk_cnt_q  <= '0;
            phase_q    <= 1'b0;
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            h1_q       <= h1_d;
            h0_q       <= h0_d;
            m1_q       <= m1_d;
            m0_q       <= m0_d;
            pre_q      <= pre_d;
            btn_mode_q <= tc.btn_mode;
            btn_inc_q  <= tc.btn_inc;
`ifdef TIME_CTRL_BLINK_EN
            blk_cnt_q  <= blk_cnt_d;
            phase_q    <= phase_d;
            blank_q    <= blank_d;
`endif
        end
    end

    assign tc.hour1 = h1_q;
    assign tc.hour0 = h0_q;
    assign tc.min1  = m1_q;
    assign tc.min0  = m0_q;
    assign tc.mode  = state_q;
endmodule
